// File: rtl/qeciphy_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qeciphy_link_pkg
// Brief    : Shared state encodings and QECIPHY status constants.
// Revision : 1.0 - initial release
// ============================================================================
package qeciphy_link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_LINK = 3'd2,
        LINK_UP   = 3'd3,
        BACKOFF   = 3'd4,
        FAILED    = 3'd5
    } link_state_e;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RESET     = 3'd1;
    localparam logic [2:0] ST_WAIT_LINK = 3'd2;
    localparam logic [2:0] ST_LINK_UP   = 3'd3;
    localparam logic [2:0] ST_BACKOFF   = 3'd4;
    localparam logic [2:0] ST_FAILED    = 3'd5;

    localparam logic [3:0] LINK_READY = 4'h4;
    localparam logic [3:0] ECODE_NONE = 4'h0;

endpackage
`default_nettype wire

// File: rtl/qeciphy_link_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module   : qeciphy_link_supervisor_if
// Brief    : Control/status bundle between board control and the supervisor.
// Revision : 1.0 - initial release
// ============================================================================
interface qeciphy_link_supervisor_if #(
    parameter int RETRY_W = 4
);
    logic               enable;
    logic [3:0]         status;
    logic [3:0]         ecode;
    logic               rx_data_error;
    logic               clear_counters;
    logic               phy_rst_n;
    logic               tx_enable;
    logic               link_up;
    logic               failed;
    logic [RETRY_W-1:0] retry_cnt;
    logic [15:0]        drop_cnt;
    logic [3:0]         last_ecode;
    logic [2:0]         state_o;

    modport master (
        output enable, status, ecode, rx_data_error, clear_counters,
        input  phy_rst_n, tx_enable, link_up, failed,
        input  retry_cnt, drop_cnt, last_ecode, state_o
    );

    modport slave (
        input  enable, status, ecode, rx_data_error, clear_counters,
        output phy_rst_n, tx_enable, link_up, failed,
        output retry_cnt, drop_cnt, last_ecode, state_o
    );
endinterface
`default_nettype wire

// File: rtl/qeciphy_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : qeciphy_cycle_timer
// Brief    : Loadable up-counter flagging when the count equals a terminal.
// Revision : 1.0 - initial release
// ============================================================================
module qeciphy_cycle_timer #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] terminal,
    output logic                  done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == terminal);
endmodule
`default_nettype wire

// File: rtl/qeciphy_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : qeciphy_link_supervisor
// Brief    : QECIPHY bring-up, fault detection and bounded-retry recovery.
// Revision : 1.0 - initial release
// ============================================================================
module qeciphy_link_supervisor
    import qeciphy_link_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int LINK_TIMEOUT   = 1048576,
    parameter int STABLE_CYCLES  = 256,
    parameter int BACKOFF_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_W        = 4
) (
    input  wire logic              ACLK,
    input  wire logic              ARSTn,
    qeciphy_link_supervisor_if.slave lnk
);
    localparam int TIMER_W  = 32;
    localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);

    logic [2:0]         state, state_nxt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [15:0]        drop_cnt;
    logic [3:0]         last_ecode;
    logic [STABLE_W-1:0] stable_cnt;
    logic [TIMER_W-1:0] terminal;
    logic good, stable_hit, fault_up, timer_done, timer_load;
    logic retry_path, capture, drop_inc, retry_max;

    assign good       = (lnk.status == LINK_READY) && (lnk.ecode == ECODE_NONE);
    assign stable_hit = good && (stable_cnt == STABLE_W'(STABLE_CYCLES - 1));
    assign fault_up   = (lnk.status != LINK_READY) || (lnk.ecode != ECODE_NONE)
                        || lnk.rx_data_error;
    assign retry_max  = (retry_cnt == RETRY_W'(MAX_RETRIES));
    assign timer_load = (state_nxt != state);

    always_comb begin
        case (state)
            ST_RESET:     terminal = TIMER_W'(RST_CYCLES - 1);
            ST_WAIT_LINK: terminal = TIMER_W'(LINK_TIMEOUT - 1);
            ST_BACKOFF:   terminal = TIMER_W'(BACKOFF_CYCLES - 1);
            default:      terminal = '1;
        endcase
    end

    qeciphy_cycle_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk      (ACLK),
        .rst_n    (ARSTn),
        .load     (timer_load),
        .terminal (terminal),
        .done     (timer_done)
    );

    always_comb begin
        state_nxt  = state;
        retry_path = 1'b0;
        capture    = 1'b0;
        drop_inc   = 1'b0;
        if (!lnk.enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_RESET;
                ST_RESET: if (timer_done) state_nxt = ST_WAIT_LINK;
                ST_WAIT_LINK: begin
                    if (lnk.ecode != ECODE_NONE) begin
                        capture    = 1'b1;
                        retry_path = 1'b1;
                    end else if (stable_hit) begin
                        state_nxt = ST_LINK_UP;
                    end else if (timer_done) begin
                        retry_path = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (fault_up) begin
                        retry_path = 1'b1;
                        drop_inc   = 1'b1;
                        capture    = (lnk.ecode != ECODE_NONE);
                    end
                end
                ST_BACKOFF: if (timer_done) state_nxt = ST_RESET;
                ST_FAILED:  state_nxt = ST_FAILED;
                default:    state_nxt = ST_IDLE;
            endcase
            if (retry_path) begin
                state_nxt = retry_max ? ST_FAILED : ST_BACKOFF;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state      <= ST_IDLE;
            retry_cnt  <= '0;
            stable_cnt <= '0;
            drop_cnt   <= '0;
            last_ecode <= '0;
        end else begin
            state <= state_nxt;

            if ((state_nxt == ST_IDLE) || (state_nxt == ST_LINK_UP && state != ST_LINK_UP)) begin
                retry_cnt <= '0;
            end else if (retry_path && !retry_max) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            // Streak only counts while in WAIT_LINK; any other state restarts it.
            if (state != ST_WAIT_LINK) begin
                stable_cnt <= '0;
            end else begin
                stable_cnt <= good ? stable_cnt + 1'b1 : '0;
            end

            if (lnk.clear_counters) begin
                drop_cnt   <= '0;
                last_ecode <= '0;
            end else begin
                if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
                if (capture) last_ecode <= lnk.ecode;
            end
        end
    end

    assign lnk.phy_rst_n  = (state == ST_WAIT_LINK) || (state == ST_LINK_UP);
    assign lnk.tx_enable  = (state == ST_LINK_UP);
    assign lnk.link_up    = (state == ST_LINK_UP);
    assign lnk.failed     = (state == ST_FAILED);
    assign lnk.retry_cnt  = retry_cnt;
    assign lnk.drop_cnt   = drop_cnt;
    assign lnk.last_ecode = last_ecode;
    assign lnk.state_o    = state;
endmodule
`default_nettype wire

// File: tb/tb_qeciphy_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_qeciphy_link_supervisor
// Brief    : Randomized bench against a phase/countdown reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qeciphy_link_supervisor;
    localparam int RST_CYCLES     = 4;
    localparam int LINK_TIMEOUT   = 64;
    localparam int STABLE_CYCLES  = 4;
    localparam int BACKOFF_CYCLES = 8;
    localparam int MAX_RETRIES    = 2;
    localparam int RETRY_W        = 4;

    localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_UP = 3, P_BACK = 4, P_FAILED = 5;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    int m_ph, m_left, m_waited, m_run, m_retries, m_drops, m_lastec;

    qeciphy_link_supervisor_if #(.RETRY_W(RETRY_W)) lnk ();

    qeciphy_link_supervisor #(
        .RST_CYCLES     (RST_CYCLES),
        .LINK_TIMEOUT   (LINK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .BACKOFF_CYCLES (BACKOFF_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .RETRY_W        (RETRY_W)
    ) dut (
        .ACLK  (clk),
        .ARSTn (rst_n),
        .lnk   (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("phy_rst_n",  32'(lnk.phy_rst_n),  32'((m_ph == P_WAIT) || (m_ph == P_UP)));
        check("tx_enable",  32'(lnk.tx_enable),  32'(m_ph == P_UP));
        check("link_up",    32'(lnk.link_up),    32'(m_ph == P_UP));
        check("failed",     32'(lnk.failed),     32'(m_ph == P_FAILED));
        check("retry_cnt",  32'(lnk.retry_cnt),  32'(m_retries));
        check("drop_cnt",   32'(lnk.drop_cnt),   32'(m_drops));
        check("last_ecode", 32'(lnk.last_ecode), 32'(m_lastec));
        check("state",      32'(lnk.state_o),    32'(m_ph));
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_left = 0; m_waited = 0; m_run = 0;
        m_retries = 0; m_drops = 0; m_lastec = 0;
    endtask

    // Reference: each timed phase counts down its remaining cycles.
    task automatic model_step(input bit en, input int st, input int ec, input bit rxe, input bit clr);
        int nxt = m_ph;
        bit take_retry = 1'b0;
        if (!en) begin
            nxt = P_IDLE;
            m_retries = 0;
        end else begin
            case (m_ph)
                P_IDLE: begin nxt = P_RESET; m_left = RST_CYCLES; end
                P_RESET: begin
                    m_left--;
                    if (m_left == 0) begin nxt = P_WAIT; m_waited = 0; m_run = 0; end
                end
                P_WAIT: begin
                    if (ec != 0) begin
                        m_lastec = ec;
                        take_retry = 1'b1;
                    end else begin
                        m_run = (st == 4) ? m_run + 1 : 0;
                        m_waited++;
                        if (m_run == STABLE_CYCLES) begin
                            nxt = P_UP;
                            m_retries = 0;
                        end else if (m_waited == LINK_TIMEOUT) begin
                            take_retry = 1'b1;
                        end
                    end
                end
                P_UP: begin
                    if (st != 4 || ec != 0 || rxe) begin
                        if (m_drops < 65535) m_drops++;
                        if (ec != 0) m_lastec = ec;
                        take_retry = 1'b1;
                    end
                end
                P_BACK: begin
                    m_left--;
                    if (m_left == 0) begin nxt = P_RESET; m_left = RST_CYCLES; end
                end
                default: ;
            endcase
            if (take_retry) begin
                if (m_retries == MAX_RETRIES) begin
                    nxt = P_FAILED;
                end else begin
                    m_retries++;
                    nxt = P_BACK;
                    m_left = BACKOFF_CYCLES;
                end
            end
        end
        if (clr) begin m_drops = 0; m_lastec = 0; end
        m_ph = nxt;
    endtask

    task automatic run_cycle(input bit en, input int st, input int ec, input bit rxe, input bit clr);
        lnk.enable         = en;
        lnk.status         = 4'(st);
        lnk.ecode          = 4'(ec);
        lnk.rx_data_error  = rxe;
        lnk.clear_counters = clr;
        model_step(en, st, ec, rxe, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int st, ec, mode;
        bit en, rxe, clr;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        lnk.enable = 1'b0; lnk.status = 4'h0; lnk.ecode = 4'h0;
        lnk.rx_data_error = 1'b0; lnk.clear_counters = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1'b1;

        for (int seg = 0; seg < 30; seg++) begin
            mode = (seg < 4) ? seg : int'($urandom_range(0, 3));
            for (int cyc = 0; cyc < 300; cyc++) begin
                en  = (cyc < 2) ? 1'b0 : ($urandom_range(0, 249) != 0);
                clr = ($urandom_range(0, 24) == 0);
                case (mode)
                    0: begin
                        st  = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 15)) : 4;
                        ec  = ($urandom_range(0, 99) == 0) ? int'($urandom_range(1, 15)) : 0;
                        rxe = ($urandom_range(0, 79) == 0);
                    end
                    1: begin st = 1; ec = 0; rxe = 1'b0; end
                    2: begin
                        st  = ($urandom_range(0, 4) == 0) ? 2 : 4;
                        ec  = 0;
                        rxe = 1'b0;
                    end
                    default: begin
                        st  = 4;
                        ec  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 15)) : 0;
                        rxe = ($urandom_range(0, 19) == 0);
                    end
                endcase
                run_cycle(en, st, ec, rxe, clr);
                if ((seg % 5 == 4) && (cyc == 150)) begin
                    #2 rst_n = 1'b0;
                    #1 model_reset();
                    check_all();
                    #1 rst_n = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/qeciphy_link_supervisor.md
Name: qeciphy_link_supervisor

Overview:
Link bring-up and recovery controller for one QECIPHY instance. It sequences the PHY reset, waits for a stable link-ready indication, gates the TX traffic source, and detects link drops, error codes and RX data-check failures. On any fault it backs off and retries, up to a bounded count, then latches a failed state. It sits between board-level control (VIO/software enable) and the QECIPHY ARSTn input and TX source enable.

Parameters:
RST_CYCLES, 16, cycles the PHY reset is held low in RESET (>=1)
LINK_TIMEOUT, 1048576, max cycles in WAIT_LINK before a retry (>=STABLE_CYCLES+1)
STABLE_CYCLES, 256, consecutive good STATUS/ECODE samples required to declare link up (>=1)
BACKOFF_CYCLES, 4096, cycles held in BACKOFF before re-entering RESET (>=1)
MAX_RETRIES, 3, retries allowed before FAILED (>=0)
RETRY_W, 4, width of retry_cnt (2^RETRY_W > MAX_RETRIES)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARSTn  in  1  asynchronous active-low reset
enable  in  1  level; 1 = bring link up, 0 = hold idle
status  in  4  QECIPHY STATUS, ACLK domain
ecode  in  4  QECIPHY ECODE, ACLK domain
rx_data_error  in  1  sticky RX checker error, ACLK domain
clear_counters  in  1  single-cycle pulse; clears drop_cnt and last_ecode
phy_rst_n  out  1  drives QECIPHY ARSTn
tx_enable  out  1  permits the TX source to assert TVALID
link_up  out  1  link stable and in service
failed  out  1  retries exhausted
retry_cnt  out  RETRY_W  retries since last LINK_UP or IDLE
drop_cnt  out  16  LINK_UP exits due to a fault, saturating at 16'hFFFF
last_ecode  out  4  most recent non-zero ecode captured on a fault
state_o  out  3  current state encoding, for ILA

Behaviour:
- ARSTn low (async): state=IDLE, all counters 0, phy_rst_n=0, tx_enable=0, link_up=0, failed=0, retry_cnt=0, drop_cnt=0, last_ecode=0.
- Outputs phy_rst_n, tx_enable, link_up, failed and state_o decode only the registered state. There is no input-to-output combinational path.
- phy_rst_n=1 only in WAIT_LINK and LINK_UP. tx_enable=link_up=1 only in LINK_UP. failed=1 only in FAILED.
- good = (status==LINK_READY) && (ecode==0).
- enable=0 in any state: next state is IDLE. This has priority over all other transitions. Entering IDLE clears retry_cnt.
- IDLE: when enable=1, go to RESET and load the timer.
- RESET: stay exactly RST_CYCLES cycles, then go to WAIT_LINK. Timer and stable counter restart at 0 on entry.
- WAIT_LINK, priority order:
  - ecode!=0: capture last_ecode, take retry path.
  - else stable counter increments while good and clears when not good. On the cycle good is seen for the STABLE_CYCLES-th consecutive time, go to LINK_UP.
  - else timer reaches LINK_TIMEOUT-1: take retry path.
- Retry path: if retry_cnt==MAX_RETRIES, go to FAILED (retry_cnt unchanged). Else increment retry_cnt and go to BACKOFF.
- LINK_UP: retry_cnt cleared on entry. The first of the following takes the retry path (retry_cnt 0→1) and increments drop_cnt (saturating):
  - status!=LINK_READY
  - ecode!=0 (also capture last_ecode)
  - rx_data_error=1
- BACKOFF: stay exactly BACKOFF_CYCLES cycles, then go to RESET.
- FAILED: stay until enable=0, then go to IDLE.
- clear_counters: clears drop_cnt and last_ecode. It wins over a same-cycle increment or capture.
- Timing example: enable rises and is sampled at edge N. state=RESET after N. phy_rst_n rises after edge N+RST_CYCLES.
- State encoding: IDLE=0, RESET=1, WAIT_LINK=2, LINK_UP=3, BACKOFF=4, FAILED=5.

Decomposition:
- Package qeciphy_link_pkg:
  - state enum (3-bit, encodings above)
  - LINK_READY=4'h4
  - ECODE_NONE=4'h0
- Sub-module qeciphy_cycle_timer: loadable free-running up-counter with a terminal-count compare. One instance is shared by RESET, WAIT_LINK and BACKOFF, reloaded on every state change.
- The FSM and stable counter stay in the top.

Test Plan:
All tests use RST_CYCLES=4, LINK_TIMEOUT=64, STABLE_CYCLES=4, BACKOFF_CYCLES=8, MAX_RETRIES=2.
1. Nominal bring-up: enable=1, status=4'h4 and ecode=0 from cycle 0 → phy_rst_n rises 4 cycles after RESET entry; link_up=tx_enable=1 4 cycles later; retry_cnt=0.
2. Timeout exhaustion: status stuck at 4'h1 → three WAIT_LINK windows of 64 cycles, each separated by BACKOFF(8)+RESET(4) with retry_cnt going 1 then 2 → FAILED with failed=1, retry_cnt=2, phy_rst_n=0.
3. Link drop: in LINK_UP, status goes to 4'h2 for 1 cycle → drop_cnt=1, retry_cnt=1, tx_enable=0 next cycle; link re-established after 8+4+4 cycles; retry_cnt back to 0.
4. Error code: in WAIT_LINK, ecode=4'h3 → last_ecode=3, immediate BACKOFF. Then clear_counters in the same cycle as a LINK_UP drop → drop_cnt=0 and last_ecode=0.
5. Glitchy status: status good 3 cycles, bad 1, good 4 → exactly one LINK_UP entry, on the 4th good of the second run.
6. Abort and reset: enable=0 mid-BACKOFF → IDLE next cycle, retry_cnt=0. ARSTn pulsed low mid-LINK_UP → all outputs at reset values asynchronously; drop_cnt=0.
